// File: rtl/vga_pkg.sv
// Shared VGA timing constants (1024x768@60, 65 MHz pixel clock) and the
// types used by the timing-stream decoder.
package vga_pkg;

    localparam int HL_BLANK_START = 1024;
    localparam int HL_SYNC_START  = 1048;
    localparam int HL_SYNC_END    = 1184;
    localparam int HL_TOTAL_TIME  = 1344;

    localparam int VL_BLANK_START = 768;
    localparam int VL_SYNC_START  = 771;
    localparam int VL_SYNC_END    = 777;
    localparam int VL_TOTAL_TIME  = 806;

    localparam int COUNT_W = 11;

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_dec_state_t;

    // Half-open window test lo <= pos < hi.
    function automatic logic in_window(input logic [COUNT_W-1:0] pos,
                                       input logic [COUNT_W-1:0] lo,
                                       input logic [COUNT_W-1:0] hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_expect.sv
// Maps a raster position to the sync/blank levels a conforming source drives there.
module vga_expect
    import vga_pkg::*;
#(
    parameter logic [COUNT_W-1:0] H_BLANK_START = COUNT_W'(HL_BLANK_START),
    parameter logic [COUNT_W-1:0] H_SYNC_START  = COUNT_W'(HL_SYNC_START),
    parameter logic [COUNT_W-1:0] H_SYNC_END    = COUNT_W'(HL_SYNC_END),
    parameter logic [COUNT_W-1:0] V_BLANK_START = COUNT_W'(VL_BLANK_START),
    parameter logic [COUNT_W-1:0] V_SYNC_START  = COUNT_W'(VL_SYNC_START),
    parameter logic [COUNT_W-1:0] V_SYNC_END    = COUNT_W'(VL_SYNC_END)
) (
    input  logic [COUNT_W-1:0] i_hc,
    input  logic [COUNT_W-1:0] i_vc,
    output logic               o_hsync,
    output logic               o_hblnk,
    output logic               o_vsync,
    output logic               o_vblnk
);

    assign o_hsync = in_window(i_hc, H_SYNC_START, H_SYNC_END);
    assign o_hblnk = (i_hc >= H_BLANK_START);
    assign o_vsync = in_window(i_vc, V_SYNC_START, V_SYNC_END);
    assign o_vblnk = (i_vc >= V_BLANK_START);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers raster position from a sync/blank stream, checks it against the
// expected timing, and reports lock, per-violation pulses and an error count.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int                 LOCK_FRAMES   = 2,
    parameter int                 ERR_W         = 8,
    parameter logic [COUNT_W-1:0] H_TOTAL       = COUNT_W'(HL_TOTAL_TIME),
    parameter logic [COUNT_W-1:0] H_BLANK_START = COUNT_W'(HL_BLANK_START),
    parameter logic [COUNT_W-1:0] H_SYNC_START  = COUNT_W'(HL_SYNC_START),
    parameter logic [COUNT_W-1:0] H_SYNC_END    = COUNT_W'(HL_SYNC_END),
    parameter logic [COUNT_W-1:0] V_TOTAL       = COUNT_W'(VL_TOTAL_TIME),
    parameter logic [COUNT_W-1:0] V_BLANK_START = COUNT_W'(VL_BLANK_START),
    parameter logic [COUNT_W-1:0] V_SYNC_START  = COUNT_W'(VL_SYNC_START),
    parameter logic [COUNT_W-1:0] V_SYNC_END    = COUNT_W'(VL_SYNC_END)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               hblnk_in,
    input  logic               vblnk_in,
    output logic [COUNT_W-1:0] hcount_out,
    output logic [COUNT_W-1:0] vcount_out,
    output logic               frame_start,
    output logic               locked,
    output logic               timing_err,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [COUNT_W-1:0] H_LAST = H_TOTAL - COUNT_W'(1);
    localparam logic [COUNT_W-1:0] V_LAST = V_TOTAL - COUNT_W'(1);
    localparam logic [3:0]         LOCK_N = 4'(LOCK_FRAMES);

    sync_dec_state_t    r_state, w_state_next;
    logic [COUNT_W-1:0] r_hc, r_vc, w_hc_next, w_vc_next;
    logic [3:0]         r_good, w_good_next;
    logic               r_origin, w_origin_next;
    logic               r_vs_prev;

    logic [COUNT_W-1:0] r_hcount, r_vcount, w_hcount_next, w_vcount_next;
    logic               r_frame_start, w_frame_start_next;
    logic               r_locked, w_locked_next;
    logic               r_timing_err, w_timing_err_next;
    logic [ERR_W-1:0]   r_err_count, w_err_count_next;

    logic w_exp_hs, w_exp_hb, w_exp_vs, w_exp_vb;
    logic w_mismatch, w_rise, w_at_origin, w_frame_end;

    vga_expect #(
        .H_BLANK_START (H_BLANK_START),
        .H_SYNC_START  (H_SYNC_START),
        .H_SYNC_END    (H_SYNC_END),
        .V_BLANK_START (V_BLANK_START),
        .V_SYNC_START  (V_SYNC_START),
        .V_SYNC_END    (V_SYNC_END)
    ) u_expect (
        .i_hc    (r_hc),
        .i_vc    (r_vc),
        .o_hsync (w_exp_hs),
        .o_hblnk (w_exp_hb),
        .o_vsync (w_exp_vs),
        .o_vblnk (w_exp_vb)
    );

    assign w_mismatch  = (hsync_in != w_exp_hs) | (hblnk_in != w_exp_hb) |
                         (vsync_in != w_exp_vs) | (vblnk_in != w_exp_vb);
    assign w_rise      = vsync_in & ~r_vs_prev;
    assign w_at_origin = (r_hc == '0) && (r_vc == '0);
    assign w_frame_end = (r_hc == H_LAST) && (r_vc == V_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Only frames that start at a seen (0,0) count toward lock.
    always_comb begin
        w_state_next  = r_state;
        w_good_next   = r_good;
        w_origin_next = r_origin;
        unique case (r_state)
            SEARCH: begin
                if (w_rise) begin
                    w_state_next  = ACQUIRE;
                    w_good_next   = '0;
                    w_origin_next = 1'b0;
                end
            end
            ACQUIRE: begin
                if (w_mismatch) begin
                    w_state_next = SEARCH;
                end else begin
                    if (w_at_origin) begin
                        w_origin_next = 1'b1;
                    end
                    if (w_frame_end && r_origin) begin
                        w_good_next = r_good + 4'd1;
                        if (w_good_next == LOCK_N) begin
                            w_state_next = LOCKED;
                        end
                    end
                end
            end
            LOCKED: begin
                if (w_mismatch) begin
                    w_state_next = SEARCH;
                end
            end
            default: w_state_next = SEARCH;
        endcase
    end

    // The vsync rising sample sits at (0, V_SYNC_START); load the position after it.
    always_comb begin
        w_hc_next = '0;
        w_vc_next = '0;
        if (r_state == SEARCH) begin
            if (w_rise) begin
                w_hc_next = COUNT_W'(1);
                w_vc_next = V_SYNC_START;
            end
        end else if (w_state_next != SEARCH) begin
            if (r_hc == H_LAST) begin
                w_hc_next = '0;
                w_vc_next = (r_vc == V_LAST) ? '0 : r_vc + COUNT_W'(1);
            end else begin
                w_hc_next = r_hc + COUNT_W'(1);
                w_vc_next = r_vc;
            end
        end
    end

    always_comb begin
        w_hcount_next      = (r_state != SEARCH) ? r_hc : '0;
        w_vcount_next      = (r_state != SEARCH) ? r_vc : '0;
        w_frame_start_next = (r_state != SEARCH) && w_at_origin;
        w_locked_next      = (r_state == LOCKED) && !w_mismatch;
        w_timing_err_next  = (r_state == LOCKED) && w_mismatch;
        w_err_count_next   = r_err_count;
        if (w_timing_err_next && (r_err_count != '1)) begin
            w_err_count_next = r_err_count + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_good        <= '0;
            r_origin      <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_frame_start <= 1'b0;
            r_locked      <= 1'b0;
            r_timing_err  <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_hc          <= w_hc_next;
            r_vc          <= w_vc_next;
            r_good        <= w_good_next;
            r_origin      <= w_origin_next;
            r_vs_prev     <= vsync_in;
            r_hcount      <= w_hcount_next;
            r_vcount      <= w_vcount_next;
            r_frame_start <= w_frame_start_next;
            r_locked      <= w_locked_next;
            r_timing_err  <= w_timing_err_next;
            r_err_count   <= w_err_count_next;
        end
    end

    assign hcount_out  = r_hcount;
    assign vcount_out  = r_vcount;
    assign frame_start = r_frame_start;
    assign locked      = r_locked;
    assign timing_err  = r_timing_err;
    assign err_count   = r_err_count;

endmodule
